hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multicycle-op stall sequencing,
// taken-branch flush, and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_start,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MD_ISSUE = 2'd2
  } state_e;

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic lu_hazard_s;
  logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s;

  assign lu_hazard_s = idex_mem_read & (idex_rt != 5'd0) &
                       ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));

  // Next-state and pipeline control; a taken branch overrides every state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    if (branch_taken) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      state_d       = RUN;
      cnt_d         = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu_hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
          end else if (id_md_start) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            cnt_d         = MD_LOAD;
            state_d       = MD_BUSY;
          end else begin
            state_d = RUN;
          end
        end
        MD_BUSY: begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
          cnt_d         = cnt_q - 4'd1;
          // <= so a corrupted zero count still drains instead of wrapping
          if (cnt_q <= 4'd1) begin
            state_d = MD_ISSUE;
          end else begin
            state_d = MD_BUSY;
          end
        end
        MD_ISSUE: begin
          if (lu_hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
          end else begin
            idex_bubble_s = 1'b0;
          end
          state_d = RUN;
        end
        default: begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
          state_d       = RUN;
          cnt_d         = 4'd0;
        end
      endcase
    end
  end

  // Saturating stall counter; flush cycles keep pc_write high so never count.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State, counter and statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Outputs are gated by reset so the pipeline is held stalled while in reset.
  assign pc_write    = reset_n & pc_write_s;
  assign ifid_write  = reset_n & ifid_write_s;
  assign ifid_flush  = reset_n & ifid_flush_s;
  assign idex_bubble = ~reset_n | idex_bubble_s;
  assign md_busy     = reset_n & (state_q == MD_BUSY);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_CYCLES = 4).
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_md_start;
  logic        branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        md_busy;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy}
  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_BUSY   = 5'b00011;
  localparam logic [4:0] C_FLUSH  = 5'b11110;
  localparam logic [4:0] C_FLBUSY = 5'b11111;
  localparam logic [4:0] C_RESET  = 5'b00010;

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .idex_mem_read(idex_mem_read),
    .idex_rt      (idex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_md_start  (id_md_start),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .md_busy      (md_busy),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, pc_write, ifid_write, ifid_flush, idex_bubble, md_busy}, {11'd0, exp});
  endtask

  task automatic idle_inputs();
    idex_mem_read = 1'b0;
    idex_rt       = 5'd0;
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    id_uses_rt    = 1'b0;
    id_md_start   = 1'b0;
    branch_taken  = 1'b0;
  endtask

  // Pulse reset between edges (called just after a negedge).
  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic load_use_inputs();
    idex_mem_read = 1'b1;
    idex_rt       = 5'd5;
    id_rs         = 5'd5;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // Reset state, held across edges
    #1;
    chk_ctl("reset_ctl", C_RESET);
    chk("reset_cnt", stall_count, 16'd0);
    @(negedge clock);
    @(negedge clock);
    chk_ctl("reset_held_ctl", C_RESET);
    reset_n = 1'b1;
    #1;
    chk_ctl("run_normal", C_NORMAL);

    // Load-use on rs
    next_cycle();
    load_use_inputs();
    #1;
    chk_ctl("lu_rs_stall", C_STALL);
    next_cycle();
    idex_mem_read = 1'b0;
    #1;
    chk_ctl("lu_after", C_NORMAL);
    chk("lu_count", stall_count, 16'd1);

    // rt match only counts when id_uses_rt
    idle_inputs();
    idex_mem_read = 1'b1;
    idex_rt       = 5'd7;
    id_rs         = 5'd3;
    id_rt         = 5'd7;
    #1;
    chk_ctl("rt_unused", C_NORMAL);
    id_uses_rt = 1'b1;
    #1;
    chk_ctl("rt_used_stall", C_STALL);
    next_cycle();
    idle_inputs();
    // Zero register never hazards
    idex_mem_read = 1'b1;
    id_uses_rt    = 1'b1;
    #1;
    chk_ctl("zero_reg", C_NORMAL);
    next_cycle();
    chk("zero_count", stall_count, 16'd2);

    // Load-use wins over md_start in RUN
    load_use_inputs();
    id_md_start = 1'b1;
    #1;
    chk_ctl("lu_md_stall", C_STALL);
    next_cycle();
    idle_inputs();
    #1;
    chk_ctl("lu_md_nobusy", C_NORMAL);
    chk("lu_md_count", stall_count, 16'd3);

    // Multicycle op: 4 stalls, 3 busy, then issue
    pulse_reset();
    id_md_start = 1'b1;
    #1;
    chk_ctl("md_c0", C_STALL);
    next_cycle();
    chk_ctl("md_c1", C_BUSY);
    next_cycle();
    chk_ctl("md_c2", C_BUSY);
    next_cycle();
    chk_ctl("md_c3", C_BUSY);
    next_cycle();
    chk_ctl("md_issue", C_NORMAL);
    chk("md_count", stall_count, 16'd4);
    next_cycle();
    id_md_start = 1'b0;
    #1;
    chk_ctl("md_after", C_NORMAL);
    chk("md_count_after", stall_count, 16'd4);

    // Load-use in MD_ISSUE stalls, then RUN
    id_md_start = 1'b1;
    repeat (4) next_cycle();
    load_use_inputs();
    #1;
    chk_ctl("issue_lu_stall", C_STALL);
    next_cycle();
    idle_inputs();
    #1;
    chk_ctl("issue_lu_run", C_NORMAL);
    chk("issue_lu_count", stall_count, 16'd9);

    // Branch on 2nd busy cycle
    pulse_reset();
    id_md_start = 1'b1;
    next_cycle();
    chk_ctl("br_busy1", C_BUSY);
    next_cycle();
    branch_taken = 1'b1;
    #1;
    chk_ctl("br_flush", C_FLBUSY);
    next_cycle();
    idle_inputs();
    #1;
    chk_ctl("br_run", C_NORMAL);
    chk("br_count", stall_count, 16'd2);

    // Branch with load-use in RUN: flush, not counted
    load_use_inputs();
    branch_taken = 1'b1;
    #1;
    chk_ctl("br_lu_flush", C_FLUSH);
    next_cycle();
    idle_inputs();
    #1;
    chk("br_lu_count", stall_count, 16'd2);

    // Async reset mid-MD_BUSY, no clock edge
    id_md_start = 1'b1;
    next_cycle();
    chk_ctl("ar_busy", C_BUSY);
    reset_n = 1'b0;
    #1;
    chk_ctl("ar_ctl", C_RESET);
    chk("ar_count", stall_count, 16'd0);
    idle_inputs();
    reset_n = 1'b1;
    #1;
    chk_ctl("ar_release", C_NORMAL);

    // Saturation
    next_cycle();
    load_use_inputs();
    repeat (70000) @(negedge clock);
    #1;
    chk("sat_count", stall_count, 16'hFFFF);
    chk_ctl("sat_ctl", C_STALL);
    next_cycle();
    chk("sat_hold", stall_count, 16'hFFFF);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
